fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined RAT core; sits directly upstream of the decode stage and its hazard/pipeline controller.
- Owns the 10-bit PC, drives a synchronous instruction ROM with 1-cycle read latency, and fills the IF/ID latch with an instruction, its PC and a valid bit.
- Obeys the controller's stall, flush, branch-load and interrupt commands.

---
 rtl/fetch_stage_if.sv | 40 ++++
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: controller commands, instruction ROM port and the IF/ID
// latch outputs. The master side is the controller/ROM environment, the slave
// side is fetch_stage.
// Optional feature macro: FETCH_PERF_CNT_EN (adds stall/bubble counters).
interface fetch_stage_if #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 18
);
  logic               stall;
  logic               flush;
  logic               pc_load;
  logic [PC_W-1:0]    load_addr;
  logic               int_take;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] id_instr;
  logic [PC_W-1:0]    id_pc;
  logic               id_valid;
  logic [PC_W-1:0]    int_ret_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]        stall_cnt;
  logic [15:0]        bubble_cnt;
`endif

  modport master (
    output stall, flush, pc_load, load_addr, int_take, imem_data,
`ifdef FETCH_PERF_CNT_EN
    input  stall_cnt, bubble_cnt,
`endif
    input  imem_addr, id_instr, id_pc, id_valid, int_ret_pc
  );

  modport slave (
    input  stall, flush, pc_load, load_addr, int_take, imem_data,
`ifdef FETCH_PERF_CNT_EN
    output stall_cnt, bubble_cnt,
`endif
    output imem_addr, id_instr, id_pc, id_valid, int_ret_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses a 1-cycle-latency ROM and
// fills the IF/ID latch. Obeys stall, flush, branch-load and interrupt.
// Optional feature macro: FETCH_PERF_CNT_EN (saturating stall/bubble counters).
module fetch_stage #(
  parameter int              PC_W     = 10,
  parameter int              INSTR_W  = 18,
  parameter logic [PC_W-1:0] INT_VEC  = 10'h3FF,
  parameter logic [PC_W-1:0] RESET_PC = 10'h000
) (
  input logic          clk,
  input logic          reset_n,
  fetch_stage_if.slave bus
);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic               inflight_valid_q, inflight_valid_d;
  logic [PC_W-1:0]    inflight_pc_q, inflight_pc_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [PC_W-1:0]    id_pc_q, id_pc_d;
  logic               id_valid_q, id_valid_d;
  logic [PC_W-1:0]    int_ret_pc_q, int_ret_pc_d;

  // Under stall the ROM re-reads the in-flight address so its word is still
  // present when the stall releases.
  assign bus.imem_addr = !reset_n  ? RESET_PC :
                         bus.stall ? inflight_pc_q : pc_q;

  assign bus.id_instr   = id_instr_q;
  assign bus.id_pc      = id_pc_q;
  assign bus.id_valid   = id_valid_q;
  assign bus.int_ret_pc = int_ret_pc_q;

  // Next-state: IF/ID update, then PC redirect priority int_take > pc_load > stall.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path infers a latch.
    pc_d             = pc_q;
    inflight_valid_d = inflight_valid_q;
    inflight_pc_d    = inflight_pc_q;
    id_instr_d       = id_instr_q;
    id_pc_d          = id_pc_q;
    id_valid_d       = id_valid_q;
    int_ret_pc_d     = int_ret_pc_q;

    if (bus.flush) begin
      id_valid_d = 1'b0;
      id_instr_d = '0;
    end else if (!bus.stall) begin
      id_instr_d = bus.imem_data;
      id_pc_d    = inflight_pc_q;
      id_valid_d = inflight_valid_q;
    end

    if (bus.int_take) begin
      // A simultaneous branch target is the true return point.
      int_ret_pc_d     = bus.pc_load ? bus.load_addr :
                         inflight_valid_q ? inflight_pc_q : pc_q;
      pc_d             = INT_VEC;
      inflight_valid_d = 1'b0;
    end else if (bus.pc_load) begin
      pc_d             = bus.load_addr;
      inflight_valid_d = 1'b0;
    end else if (!bus.stall) begin
      inflight_valid_d = 1'b1;
      inflight_pc_d    = pc_q;
      pc_d             = pc_q + 1'b1;  // wraps modulo 2^PC_W
    end

    if (bus.flush) inflight_valid_d = 1'b0;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset_n) begin
      pc_q             <= RESET_PC;
      inflight_valid_q <= 1'b0;
      inflight_pc_q    <= '0;
      id_instr_q       <= '0;
      id_pc_q          <= '0;
      id_valid_q       <= 1'b0;
      int_ret_pc_q     <= '0;
    end else begin
      pc_q             <= pc_d;
      inflight_valid_q <= inflight_valid_d;
      inflight_pc_q    <= inflight_pc_d;
      id_instr_q       <= id_instr_d;
      id_pc_q          <= id_pc_d;
      id_valid_q       <= id_valid_d;
      int_ret_pc_q     <= int_ret_pc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.bubble_cnt = bubble_cnt_q;

  // Saturating counters: stall cycles and edges that write a bubble into IF/ID.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (bus.stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    if (!id_valid_d && bubble_cnt_q != 16'hFFFF) bubble_cnt_d = bubble_cnt_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// command stream checked against a behavioural model of the fetch rules.
module tb_fetch_stage;
  localparam int PC_W    = 10;
  localparam int INSTR_W = 18;
  localparam logic [PC_W-1:0] INT_VEC = 10'h3FF;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  fetch_stage_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ROM with one cycle read latency.
  logic [INSTR_W-1:0] rom [1024];
  always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

  // Reference model state.
  typedef struct { logic v; logic [PC_W-1:0] pc; } slot_t;
  logic [PC_W-1:0]    m_pc;
  slot_t              m_if;
  slot_t              m_id;
  logic [INSTR_W-1:0] m_instr;
  logic               m_instr_known;
  logic [PC_W-1:0]    m_ret;
  int                 m_stall_cnt, m_bubble_cnt;

  function automatic logic [PC_W-1:0] exp_imem_addr();
    if (!reset_n) return 10'h000;
    return bus.stall ? m_if.pc : m_pc;
  endfunction

  task automatic model_edge();
    slot_t old_if;
    old_if = m_if;
    if (!reset_n) begin
      m_pc = 10'h000; m_if = '{1'b0, 10'h000}; m_id = '{1'b0, 10'h000};
      m_instr = '0; m_instr_known = 1'b1; m_ret = '0;
      m_stall_cnt = 0; m_bubble_cnt = 0;
      return;
    end
    if (bus.flush) begin
      m_id.v = 1'b0; m_instr = '0; m_instr_known = 1'b1;
    end else if (!bus.stall) begin
      m_id = old_if;
      m_instr = rom[old_if.pc];
      m_instr_known = old_if.v;
    end
    if (bus.stall && m_stall_cnt < 65535) m_stall_cnt++;
    if (!m_id.v && m_bubble_cnt < 65535) m_bubble_cnt++;
    if (bus.int_take) begin
      m_ret = bus.pc_load ? bus.load_addr : (old_if.v ? old_if.pc : m_pc);
      m_pc = INT_VEC; m_if.v = 1'b0;
    end else if (bus.pc_load) begin
      m_pc = bus.load_addr; m_if.v = 1'b0;
    end else if (!bus.stall) begin
      m_if = '{1'b1, m_pc};
      m_pc = PC_W'((int'(m_pc) + 1) % 1024);
    end
    if (bus.flush) m_if.v = 1'b0;
  endtask

  // Advance one clock; outputs are sampled at the following falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.flush = 0; bus.pc_load = 0; bus.int_take = 0;
    bus.load_addr = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    tick(); tick();
    total++;
    if (bus.imem_addr !== 10'h000) begin bad++; $display("FAIL reset_imem_addr got=%h want=000", bus.imem_addr); end
    total++;
    if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL reset_id_valid got=%b want=0", bus.id_valid); end
    total++;
    if (bus.id_pc !== 10'h000 || bus.id_instr !== 18'h0) begin
      bad++; $display("FAIL reset_id got pc=%h instr=%h want 000/00000", bus.id_pc, bus.id_instr);
    end
    total++;
    if (bus.int_ret_pc !== 10'h000) begin bad++; $display("FAIL reset_ret_pc got=%h want=000", bus.int_ret_pc); end
`ifdef FETCH_PERF_CNT_EN
    total++;
    if (bus.stall_cnt !== 16'd0 || bus.bubble_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_cnt got=%0d/%0d want 0/0", bus.stall_cnt, bus.bubble_cnt);
    end
`endif
  endtask

  // Release reset and stream until id_pc reaches 5.
  task automatic test_stream();
    reset_n = 1'b1;
    tick();
    total++;
    if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL stream_first_edge id_valid got=%b want=0", bus.id_valid); end
    for (int i = 0; i <= 5; i++) begin
      tick();
      total++;
      if (bus.id_valid !== 1'b1 || bus.id_pc !== PC_W'(i) || bus.id_instr !== INSTR_W'(i + 'h100)) begin
        bad++;
        $display("FAIL stream[%0d] got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 i, bus.id_valid, bus.id_pc, bus.id_instr, i, i + 'h100);
      end
    end
  endtask

  task automatic test_stall();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (bus.imem_addr !== 10'h006) begin bad++; $display("FAIL stall_imem_addr[%0d] got=%h want=006", i, bus.imem_addr); end
      tick();
      total++;
      if (bus.id_pc !== 10'h005 || bus.id_valid !== 1'b1) begin
        bad++; $display("FAIL stall_hold[%0d] got pc=%h v=%b want pc=005 v=1", i, bus.id_pc, bus.id_valid);
      end
    end
    bus.stall = 1'b0;
    for (int i = 6; i <= 7; i++) begin
      tick();
      total++;
      if (bus.id_pc !== PC_W'(i) || bus.id_instr !== INSTR_W'(i + 'h100) || bus.id_valid !== 1'b1) begin
        bad++; $display("FAIL stall_release got pc=%h instr=%h want pc=%h instr=%h",
                        bus.id_pc, bus.id_instr, i, i + 'h100);
      end
    end
  endtask

  task automatic test_branch_flush();
    bus.pc_load = 1'b1; bus.load_addr = 10'h2A0; bus.flush = 1'b1;
    tick();
    idle_inputs();
    total++;
    if (bus.id_valid !== 1'b0 || bus.id_instr !== 18'h0) begin
      bad++; $display("FAIL branch_bubble got v=%b instr=%h want v=0 instr=0", bus.id_valid, bus.id_instr);
    end
    tick();
    total++;
    if (bus.id_valid !== 1'b0) begin bad++; $display("FAIL branch_gap got v=%b want=0", bus.id_valid); end
    tick();
    total++;
    if (bus.id_valid !== 1'b1 || bus.id_pc !== 10'h2A0 || bus.id_instr !== 18'h003A0) begin
      bad++; $display("FAIL branch_target got v=%b pc=%h instr=%h want v=1 pc=2a0 instr=003a0",
                      bus.id_valid, bus.id_pc, bus.id_instr);
    end
  endtask

  task automatic test_int_with_branch();
    bus.int_take = 1'b1; bus.pc_load = 1'b1; bus.load_addr = 10'h050;
    tick();
    idle_inputs();
    total++;
    if (bus.int_ret_pc !== 10'h050) begin bad++; $display("FAIL int_ret_pc got=%h want=050", bus.int_ret_pc); end
    total++;
    if (bus.imem_addr !== INT_VEC) begin bad++; $display("FAIL int_vector got=%h want=3ff", bus.imem_addr); end
    tick();
    total++;
    if (bus.imem_addr !== 10'h000) begin bad++; $display("FAIL int_wrap_addr got=%h want=000", bus.imem_addr); end
    tick();
    total++;
    if (bus.id_valid !== 1'b1 || bus.id_pc !== 10'h3FF || bus.id_instr !== 18'h004FF) begin
      bad++; $display("FAIL int_fetch got v=%b pc=%h instr=%h want v=1 pc=3ff instr=004ff",
                      bus.id_valid, bus.id_pc, bus.id_instr);
    end
    tick();
    total++;
    if (bus.id_pc !== 10'h000 || bus.id_instr !== 18'h00100) begin
      bad++; $display("FAIL int_wrap_fetch got pc=%h instr=%h want pc=000 instr=00100", bus.id_pc, bus.id_instr);
    end
  endtask

  task automatic test_reset_mid();
    tick(); tick();
    reset_n = 1'b0; bus.stall = 1'b1;
    #1;
    total++;
    if (bus.imem_addr !== 10'h000) begin bad++; $display("FAIL midreset_addr got=%h want=000", bus.imem_addr); end
    tick();
    reset_n = 1'b1; bus.stall = 1'b0;
    #1;
    total++;
    if (bus.id_valid !== 1'b0 || bus.imem_addr !== 10'h000) begin
      bad++; $display("FAIL midreset_state got v=%b addr=%h want v=0 addr=000", bus.id_valid, bus.imem_addr);
    end
    tick(); tick();
    total++;
    if (bus.id_valid !== 1'b1 || bus.id_pc !== 10'h000 || bus.id_instr !== 18'h00100) begin
      bad++; $display("FAIL midreset_restart got v=%b pc=%h instr=%h want v=1 pc=000 instr=00100",
                      bus.id_valid, bus.id_pc, bus.id_instr);
    end
  endtask

  // Random command mix compared every cycle against the model.
  task automatic test_random();
    int errs;
    errs = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      reset_n       = ($urandom_range(0, 99) >= 2);
      bus.stall     = ($urandom_range(0, 99) < 25);
      bus.flush     = ($urandom_range(0, 99) < 10);
      bus.pc_load   = ($urandom_range(0, 99) < 8);
      bus.int_take  = ($urandom_range(0, 99) < 4);
      bus.load_addr = PC_W'($urandom_range(0, 1023));
      #1;
      total++;
      if (bus.imem_addr !== exp_imem_addr()) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rand_imem_addr cyc=%0d got=%h want=%h", cyc, bus.imem_addr, exp_imem_addr());
      end
      tick();
      total++;
      if (bus.id_valid !== m_id.v || bus.id_pc !== m_id.pc || bus.int_ret_pc !== m_ret ||
          (m_instr_known && bus.id_instr !== m_instr)
`ifdef FETCH_PERF_CNT_EN
          || bus.stall_cnt !== 16'(m_stall_cnt) || bus.bubble_cnt !== 16'(m_bubble_cnt)
`endif
         ) begin
        bad++; errs++;
        if (errs < 10)
          $display("FAIL rand_outputs cyc=%0d got v=%b pc=%h instr=%h ret=%h want v=%b pc=%h instr=%h ret=%h",
                   cyc, bus.id_valid, bus.id_pc, bus.id_instr, bus.int_ret_pc,
                   m_id.v, m_id.pc, m_instr, m_ret);
      end
    end
    reset_n = 1'b1;
    idle_inputs();
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf_cnt();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
    bus.stall = 1'b1;
    repeat (4) tick();
    bus.stall = 1'b0; bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    total++;
    if (bus.stall_cnt !== 16'd4) begin bad++; $display("FAIL perf_stall_cnt got=%0d want=4", bus.stall_cnt); end
    total++;
    if (bus.bubble_cnt < 16'd1 || bus.bubble_cnt !== 16'(m_bubble_cnt)) begin
      bad++; $display("FAIL perf_bubble_cnt got=%0d want=%0d", bus.bubble_cnt, m_bubble_cnt);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = INSTR_W'(i + 'h100);
    reset_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_branch_flush();
    test_int_with_branch();
    test_reset_mid();
    test_random();
`ifdef FETCH_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
